assay_scheduler: RTL and testbench



---
 rtl/assay_pkg.sv | 44 ++++
 rtl/assay_scheduler_rr_arbiter.sv | 43 ++++
 rtl/assay_scheduler.sv | 161 ++++++++++++++++
 tb/tb_assay_scheduler.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/assay_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : assay_pkg
//  Description : Shared state encoding, width helpers and default phase
//                lengths for the assay channel scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package assay_pkg;

    // Scheduler phases; explicit 3-bit encoding
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        MIX    = 3'd2,
        DETECT = 3'd3,
        REPORT = 3'd4
    } state_t;

    localparam int c_n_ch_def     = 12;
    localparam int c_load_cyc_def = 16;
    localparam int c_mix_cyc_def  = 64;
    localparam int c_det_cyc_def  = 8;
    localparam int c_dw_def       = 12;

    // Channel index width; at least one bit even for tiny arrays
    function automatic int chw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Result sum width: room for DET_CYC full-scale samples without overflow
    function automatic int sumw(input int dw, input int det_cyc);
        return dw + $clog2(det_cyc + 1);
    endfunction

    // Phase counter width: must hold the largest (phase length - 1)
    function automatic int cntw(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/assay_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Returns the first set
//                request at or after the pointer, wrapping past N-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 12,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_grant,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    int   w_j;
    logic w_found;

    // Scan N positions starting at the pointer; first hit wins
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = |i_req;
        w_found = 1'b0;
        w_j     = 0;
        for (int k = 0; k < N; k++) begin
            w_j = int'(i_ptr) + k;
            if (w_j >= N) begin
                w_j = w_j - N;
            end
            if (!w_found && i_req[w_j[W-1:0]]) begin
                w_found              = 1'b1;
                o_grant[w_j[W-1:0]]  = 1'b1;
                o_idx                = w_j[W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/assay_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : assay_scheduler
//  Description : Runs one two-reagent assay channel at a time through
//                LOAD -> MIX -> DETECT -> REPORT, granting waiting channels
//                round-robin and returning one result per assay.
//  Revision    : 1.0 - initial release
// ============================================================================
module assay_scheduler
    import assay_pkg::*;
#(
    parameter int N_CH     = c_n_ch_def,
    parameter int LOAD_CYC = c_load_cyc_def,
    parameter int MIX_CYC  = c_mix_cyc_def,
    parameter int DET_CYC  = c_det_cyc_def,
    parameter int DW       = c_dw_def,
    localparam int CHW     = chw(N_CH),
    localparam int SUMW    = sumw(DW, DET_CYC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] req,
    output logic [N_CH-1:0] valve_a,
    output logic [N_CH-1:0] valve_b,
    output logic [N_CH-1:0] mix_en,
    output logic [CHW-1:0]  det_sel,
    output logic            det_en,
    input  logic [DW-1:0]   det_data,
    input  logic            det_valid,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [CHW-1:0]  res_ch,
    output logic [SUMW-1:0] res_sum,
    output logic            res_err,
    output logic [N_CH-1:0] done,
    output logic            busy
);

    localparam int c_cntw = cntw(LOAD_CYC, MIX_CYC, DET_CYC);
    localparam int c_vw   = $clog2(DET_CYC + 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CHW-1:0]    r_ptr;
    logic [CHW-1:0]    r_ch;
    logic [N_CH-1:0]   r_mask;
    logic [c_cntw-1:0] r_cnt;
    logic [c_cntw-1:0] w_reload;
    logic [SUMW-1:0]   r_sum;
    logic [c_vw-1:0]   r_nvalid;
    logic [N_CH-1:0]   r_done;
    logic [N_CH-1:0]   w_grant;
    logic [CHW-1:0]    w_idx;
    logic              w_any;
    logic              w_cnt_zero;

    rr_arbiter #(
        .N (N_CH),
        .W (CHW)
    ) u_arb (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_cnt_zero = (r_cnt == '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: each timed phase ends when the shared counter reaches zero
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any)      w_state_nxt = LOAD;
            LOAD:    if (w_cnt_zero) w_state_nxt = MIX;
            MIX:     if (w_cnt_zero) w_state_nxt = DETECT;
            DETECT:  if (w_cnt_zero) w_state_nxt = REPORT;
            REPORT:  if (res_ready)  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Counter reload value for the phase being entered
    always_comb begin
        w_reload = '0;
        case (w_state_nxt)
            LOAD:    w_reload = c_cntw'(LOAD_CYC - 1);
            MIX:     w_reload = c_cntw'(MIX_CYC - 1);
            DETECT:  w_reload = c_cntw'(DET_CYC - 1);
            default: w_reload = '0;
        endcase
    end

    // Phase counter, channel latch, detector accumulation and accept handling
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr    <= '0;
            r_ch     <= '0;
            r_mask   <= '0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_nvalid <= '0;
            r_done   <= '0;
        end else begin
            r_done <= '0;
            if (w_state_nxt != r_state) begin
                r_cnt <= w_reload;
            end else if (!w_cnt_zero) begin
                r_cnt <= r_cnt - c_cntw'(1);
            end
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_ch     <= w_idx;
                        r_mask   <= w_grant;
                        r_sum    <= '0;
                        r_nvalid <= '0;
                    end
                end
                DETECT: begin
                    if (det_valid) begin
                        r_sum    <= r_sum + SUMW'(det_data);
                        r_nvalid <= r_nvalid + c_vw'(1);
                    end
                end
                REPORT: begin
                    if (res_ready) begin
                        r_done <= r_mask;
                        r_ptr  <= (r_ch == CHW'(N_CH - 1)) ? '0 : r_ch + CHW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode from registered state only; the channel mask limits
    // activity to the single granted channel
    assign valve_a   = (r_state == LOAD) ? r_mask : '0;
    assign valve_b   = (r_state == LOAD) ? r_mask : '0;
    assign mix_en    = (r_state == MIX)  ? r_mask : '0;
    assign det_en    = (r_state == DETECT);
    assign det_sel   = ((r_state == DETECT) || (r_state == REPORT)) ? r_ch : '0;
    assign res_valid = (r_state == REPORT);
    assign res_ch    = (r_state == REPORT) ? r_ch  : '0;
    assign res_sum   = (r_state == REPORT) ? r_sum : '0;
    assign res_err   = (r_state == REPORT) && (r_nvalid == '0);
    assign done      = r_done;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_assay_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_assay_scheduler
//  Description : Self-checking bench for assay_scheduler: per-cycle model
//                comparison, a table of single assays, reset/round-robin
//                sequences and a randomized run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_assay_scheduler;

    localparam int N    = 12;
    localparam int L    = 16;
    localparam int M    = 64;
    localparam int D    = 8;
    localparam int DW   = 12;
    localparam int CHW  = 4;
    localparam int SUMW = 16;
    localparam int LAT  = 1 + L + M + D;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    valve_a, valve_b, mix_en, done;
    logic [CHW-1:0]  det_sel, res_ch;
    logic            det_en, det_valid, res_valid, res_ready, res_err, busy;
    logic [DW-1:0]   det_data;
    logic [SUMW-1:0] res_sum;

    always #5 clk = ~clk;

    assay_scheduler #(
        .N_CH(N), .LOAD_CYC(L), .MIX_CYC(M), .DET_CYC(D), .DW(DW)
    ) dut (
        .clk(clk), .rst(rst), .req(req),
        .valve_a(valve_a), .valve_b(valve_b), .mix_en(mix_en),
        .det_sel(det_sel), .det_en(det_en),
        .det_data(det_data), .det_valid(det_valid),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_ch(res_ch), .res_sum(res_sum), .res_err(res_err),
        .done(done), .busy(busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an assay is "active" from its grant; its phase follows
    // from the number of cycles elapsed since the grant.
    bit         m_act  = 0;
    int         m_ch   = 0;
    int         m_age  = 0;
    int         m_sum  = 0;
    int         m_nv   = 0;
    int         m_ptr  = 0;
    logic [N-1:0] m_done = '0;

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    task automatic tick();
        logic [N-1:0] oh;
        bit in_load, in_mix, in_det, in_rep;
        @(posedge clk);
        #1;
        if (rst) begin
            m_act  = 0;
            m_ptr  = 0;
            m_done = '0;
        end else begin
            m_done = '0;
            if (!m_act) begin
                if (req != '0) begin
                    m_ch  = pick(req, m_ptr);
                    m_act = 1;
                    m_age = 1;
                    m_sum = 0;
                    m_nv  = 0;
                end
            end else begin
                if (m_age > L + M && m_age <= L + M + D && det_valid) begin
                    m_sum += int'(det_data);
                    m_nv++;
                end
                if (m_age > L + M + D && res_ready) begin
                    m_act  = 0;
                    m_done = N'(1) << m_ch;
                    m_ptr  = (m_ch + 1) % N;
                end else begin
                    m_age++;
                end
            end
        end
        oh      = m_act ? (N'(1) << m_ch) : '0;
        in_load = m_act && m_age >= 1 && m_age <= L;
        in_mix  = m_act && m_age > L && m_age <= L + M;
        in_det  = m_act && m_age > L + M && m_age <= L + M + D;
        in_rep  = m_act && m_age > L + M + D;
        chk("valve_a", valve_a, in_load ? oh : '0);
        chk("valve_b", valve_b, in_load ? oh : '0);
        chk("mix_en", mix_en, in_mix ? oh : '0);
        chk("det_en", det_en, in_det);
        chk("res_valid", res_valid, in_rep);
        chk("busy", busy, m_act);
        chk("done", done, m_done);
        if (in_det || in_rep) chk("det_sel", det_sel, m_ch);
        if (in_rep) begin
            chk("res_ch", res_ch, m_ch);
            chk("res_sum", res_sum, m_sum);
            chk("res_err", res_err, m_nv == 0);
        end
    endtask

    typedef struct {
        logic [N-1:0] req;
        int           data;
        int           mode;   // 0 always valid, 1 never valid, 2 alternating
        int           delay;  // REPORT cycles with res_ready low before accept
        int           exp_ch;
        int           exp_sum;
        bit           exp_err;
    } vec_t;

    vec_t tbl[6];
    bit   alt = 0;

    task automatic drive_det(input int mode, input int data);
        alt      = ~alt;
        det_data = DW'(data);
        det_valid = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : alt;
    endtask

    initial begin
        int lat, ng, k, idx;
        logic [N-1:0] prev_va;

        rst = 1'b1; req = '0; det_valid = 1'b0; det_data = '0; res_ready = 1'b0;
        repeat (3) tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_valves", valve_a | valve_b | mix_en, '0);
        rst = 1'b0;
        tick();

        // req, data, mode, delay, ch, sum, err (pointer carries between rows)
        tbl[0] = '{12'h001,  100, 0,  0,  0,   800, 1'b0};
        tbl[1] = '{12'h800, 4095, 0,  0, 11, 32760, 1'b0};
        tbl[2] = '{12'h020,    7, 1,  0,  5,     0, 1'b1};
        tbl[3] = '{12'h041,   10, 2,  0,  6,    40, 1'b0};
        tbl[4] = '{12'h041,    1, 0, 20,  0,     8, 1'b0};
        tbl[5] = '{12'h002,    0, 0,  0,  1,     0, 1'b0};

        for (int t = 0; t < 6; t++) begin
            req = tbl[t].req;
            res_ready = 1'b0;
            drive_det(tbl[t].mode, tbl[t].data);
            tick();
            req = '0;   // request withdrawn right after the grant
            lat = 1;
            while (!res_valid && lat < 200) begin
                drive_det(tbl[t].mode, tbl[t].data);
                tick();
                lat++;
            end
            det_valid = 1'b0;
            chk("latency", lat, LAT);
            chk("tbl_res_ch", res_ch, tbl[t].exp_ch);
            chk("tbl_res_sum", res_sum, tbl[t].exp_sum);
            chk("tbl_res_err", res_err, tbl[t].exp_err);
            for (int h = 0; h < tbl[t].delay; h++) begin
                tick();
                chk("hold_valid", res_valid, 1'b1);
                chk("hold_sum", res_sum, tbl[t].exp_sum);
                chk("hold_valves", valve_a | valve_b | mix_en, '0);
            end
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            chk("tbl_done", done, N'(1) << tbl[t].exp_ch);
            chk("tbl_idle", busy, 1'b0);
        end

        // Reset in the middle of MIX on channel 3
        req = 12'h008;
        tick();
        req = '0;
        repeat (40) tick();
        chk("mid_mix", mix_en, 12'h008);
        rst = 1'b1;
        tick();
        chk("abort_valves", valve_a | valve_b, '0);
        chk("abort_mix", mix_en, '0);
        chk("abort_det_en", det_en, 1'b0);
        chk("abort_res_valid", res_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        rst = 1'b0;
        tick();

        // All requests held: grants must rotate 0..11 then back to 0
        req = '1; res_ready = 1'b1; det_valid = 1'b1; det_data = 12'd3;
        ng = 0; k = 0; prev_va = '0;
        while (ng < 13 && k < 1500) begin
            tick();
            k++;
            if (valve_a != '0 && prev_va == '0) begin
                idx = -1;
                for (int b = 0; b < N; b++) if (valve_a[b]) idx = b;
                chk("rr_order", idx, ng % N);
                ng++;
            end
            prev_va = valve_a;
        end
        chk("rr_grants", ng, 13);
        req = '0;
        k = 0;
        while (busy && k < 200) begin tick(); k++; end
        chk("rr_drain", busy, 1'b0);

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            rst       = ($urandom_range(0, 1499) == 0);
            req       = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            res_ready = ($urandom_range(0, 2) == 0);
            det_valid = $urandom_range(0, 1);
            det_data  = DW'($urandom);
            tick();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
